// File: rtl/uart_tx_scheduler_pkg.sv
// Shared traffic-controller definitions: scheduler state encoding,
// ASCII command bytes and requester slot assignments.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } sched_state_t;

    localparam logic [7:0] ASCII_C = 8'h43;
    localparam logic [7:0] ASCII_N = 8'h4E;
    localparam logic [7:0] ASCII_S = 8'h53;
    localparam logic [7:0] ASCII_E = 8'h45;
    localparam logic [7:0] ASCII_W = 8'h57;

    localparam int REQ_TELEM = 0;
    localparam int REQ_ACK   = 1;
    localparam int REQ_FAULT = 2;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side byte bus of the UART scheduler: one req/data/last
// lane per producer and a one-hot capture acknowledge back.
interface uart_tx_scheduler_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   ack;

    modport master (output req, output req_data, output req_last, input ack);
    modport slave  (input req, input req_data, input req_last, output ack);
endinterface

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Combinational round-robin search: first set request bit at or after
// the start pointer, wrapping at N_REQ.
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_start,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);

    logic [PTR_W:0] w_pos;

    // Scan from the farthest slot back to the start so the nearest hit wins
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_pos = {1'b0, i_start} + (PTR_W+1)'(k);
            if (w_pos >= (PTR_W+1)'(N_REQ)) begin
                w_pos = w_pos - (PTR_W+1)'(N_REQ);
            end
            if (i_req[w_pos[PTR_W-1:0]]) begin
                o_idx   = w_pos[PTR_W-1:0];
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx serializer among N_REQ byte producers. Grants are
// round-robin at frame boundaries; a locked frame keeps the line until
// its last byte. Paces on uart_tx busy (must see it rise, then fall).
import traffic_pkg::*;

module uart_tx_scheduler #(
    parameter int N_REQ     = 3,
    parameter int WD_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_tx_scheduler_if.slave  req_bus,
    input  logic                i_tx_busy,
    output logic                o_tx_start,
    output logic [7:0]          o_tx_data,
    output logic [2:0]          o_grant_id,
    output logic                o_frame_active,
    output logic                o_frame_abort,
    output logic                o_wd_error
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = (WD_CYCLES > 2) ? $clog2(WD_CYCLES) : 1;

    sched_state_t     r_state, w_state_nxt;
    logic [PTR_W-1:0] r_rr_ptr, w_rr_nxt;
    logic [PTR_W-1:0] r_grant, w_grant_nxt;
    logic             r_lock, w_lock_nxt;
    logic [WD_W-1:0]  r_wd, w_wd_nxt;
    logic [7:0]       r_tx_data, w_data_nxt;
    logic             r_tx_start;
    logic [N_REQ-1:0] r_ack;
    logic             r_frame_active;
    logic             r_frame_abort, w_abort_nxt;
    logic             r_wd_error, w_wderr_nxt;
    logic [PTR_W-1:0] w_pick_idx;
    logic             w_pick_valid;
    logic             w_launch;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(N_REQ - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_req   (req_bus.req),
        .i_start (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Next-state, grant bookkeeping and pulse decisions.
    // The watchdog counts from the tx_start cycle, so WD_CYCLES covers the
    // launch cycle plus the wait for busy to rise.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_grant_nxt = r_grant;
        w_lock_nxt  = r_lock;
        w_wd_nxt    = r_wd;
        w_data_nxt  = r_tx_data;
        w_abort_nxt = 1'b0;
        w_wderr_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid && !i_tx_busy) begin
                    w_grant_nxt = w_pick_idx;
                    w_data_nxt  = req_bus.req_data[{w_pick_idx, 3'b000} +: 8];
                    w_lock_nxt  = ~req_bus.req_last[w_pick_idx];
                    w_wd_nxt    = '0;
                    w_state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_wd_nxt    = r_wd + 1'b1;
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (i_tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_wd == WD_W'(WD_CYCLES - 1)) begin
                    w_wderr_nxt = 1'b1;
                    w_lock_nxt  = 1'b0;
                    w_rr_nxt    = ptr_inc(r_grant);
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    if (r_lock && req_bus.req[r_grant]) begin
                        w_data_nxt  = req_bus.req_data[{r_grant, 3'b000} +: 8];
                        w_lock_nxt  = ~req_bus.req_last[r_grant];
                        w_wd_nxt    = '0;
                        w_state_nxt = ST_LAUNCH;
                    end else begin
                        w_abort_nxt = r_lock;
                        w_lock_nxt  = 1'b0;
                        w_rr_nxt    = ptr_inc(r_grant);
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_launch = (w_state_nxt == ST_LAUNCH);

    // FSM state and grant control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_lock   <= 1'b0;
            r_wd     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_grant  <= w_grant_nxt;
            r_lock   <= w_lock_nxt;
            r_wd     <= w_wd_nxt;
        end
    end

    // Registered outputs, computed from the next state so strobes line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data      <= 8'h00;
            r_tx_start     <= 1'b0;
            r_ack          <= '0;
            r_frame_active <= 1'b0;
            r_frame_abort  <= 1'b0;
            r_wd_error     <= 1'b0;
        end else begin
            r_tx_data      <= w_data_nxt;
            r_tx_start     <= w_launch;
            r_ack          <= w_launch ? (N_REQ'(1) << w_grant_nxt) : '0;
            r_frame_active <= (w_state_nxt != ST_IDLE);
            r_frame_abort  <= w_abort_nxt;
            r_wd_error     <= w_wderr_nxt;
        end
    end

    assign req_bus.ack     = r_ack;
    assign o_tx_start      = r_tx_start;
    assign o_tx_data       = r_tx_data;
    assign o_grant_id      = 3'(r_grant);
    assign o_frame_active  = r_frame_active;
    assign o_frame_abort   = r_frame_abort;
    assign o_wd_error      = r_wd_error;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: table of single-byte grant vectors,
// hand sequences for frames/abort/watchdog/reset, and randomized frame
// sets checked against a queue-level round-robin reference model.
module tb_uart_tx_scheduler;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } ent_t;

    typedef struct {
        logic [2:0] mask;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [2:0] exp_g;
        logic [7:0] exp_d;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [2:0] grant_id;
    logic       frame_active;
    logic       frame_abort;
    logic       wd_error;

    uart_tx_scheduler_if #(.N_REQ(3)) bus ();

    uart_tx_scheduler #(.N_REQ(3), .WD_CYCLES(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_bus        (bus),
        .i_tx_busy      (tx_busy),
        .o_tx_start     (tx_start),
        .o_tx_data      (tx_data),
        .o_grant_id     (grant_id),
        .o_frame_active (frame_active),
        .o_frame_abort  (frame_abort),
        .o_wd_error     (wd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // uart_tx stand-in: busy rises the cycle after start, holds busy_len cycles
    int busy_len;
    logic busy_en;
    int bcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy <= 1'b0;
            bcnt    <= 0;
        end else if (tx_start && busy_en) begin
            tx_busy <= 1'b1;
            bcnt    <= busy_len;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else if (bcnt == 1) begin
            bcnt    <= 0;
            tx_busy <= 1'b0;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int fall_cyc = -1000;
    logic prev_busy = 1'b0;
    int n_starts = 0;
    int n_abort = 0;
    int n_wd = 0;
    int wd_cyc = 0;
    logic wd_fa = 1'b0;
    logic [2:0] st_g [256];
    logic [7:0] st_d [256];
    int st_c [256];
    int st_gap [256];

    ent_t rb [3][64];
    int rh [3];
    int rt [3];

    logic [2:0] eg [64];
    logic [7:0] ed [64];
    int n_exp;
    int exp_ab;
    int sc_base;

    vec_t vt [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_update();
        for (int i = 0; i < 3; i++) begin
            if (rh[i] < rt[i]) begin
                bus.req[i]            = 1'b1;
                bus.req_data[8*i +: 8] = rb[i][rh[i]].data;
                bus.req_last[i]       = rb[i][rh[i]].last;
            end else begin
                bus.req[i]      = 1'b0;
                bus.req_last[i] = 1'b0;
            end
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        rb[i][rt[i]] = '{data: d, last: l};
        rt[i]++;
    endtask

    // one clock: sample outputs on the falling edge, then requesters react to ack
    task automatic step();
        @(negedge clk);
        cyc++;
        if (prev_busy && !tx_busy) fall_cyc = cyc;
        prev_busy = tx_busy;
        if (tx_start || bus.ack != 3'b000)
            check("ack_onehot_with_start", 32'(bus.ack), tx_start ? 32'(3'b001 << grant_id) : 32'd0);
        if (tx_start && n_starts < 256) begin
            st_g[n_starts]   = grant_id;
            st_d[n_starts]   = tx_data;
            st_c[n_starts]   = cyc;
            st_gap[n_starts] = cyc - fall_cyc;
            n_starts++;
        end
        if (frame_abort) n_abort++;
        if (wd_error) begin
            n_wd++;
            wd_cyc = cyc;
            wd_fa  = frame_active;
        end
        for (int i = 0; i < 3; i++)
            if (bus.ack[i] && rh[i] < rt[i]) rh[i]++;
        drive_update();
    endtask

    task automatic wait_starts(input int n, input int budget);
        int k = 0;
        while (n_starts < n && k < budget) begin
            step();
            k++;
        end
        check("start_count", n_starts, n);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        do begin
            step();
            k++;
        end while ((frame_active || tx_busy) && k < budget);
        check("back_to_idle", {31'd0, frame_active}, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rh[i] = 0;
            rt[i] = 0;
        end
        drive_update();
        @(negedge clk);
        check("reset_state", {tx_start, bus.ack, frame_active, frame_abort, wd_error, grant_id, tx_data}, 0);
        rst_n = 1'b1;
        prev_busy = 1'b0;
        fall_cyc = -1000;
        step();
    endtask

    // reference: whole frames, round-robin from ptr, abort when a lane runs dry mid-frame
    task automatic run_model();
        int h [3];
        int ptr;
        int g;
        bit done;
        ptr = 0;
        n_exp = 0;
        exp_ab = 0;
        for (int i = 0; i < 3; i++) h[i] = rh[i];
        while (h[0] < rt[0] || h[1] < rt[1] || h[2] < rt[2]) begin
            g = -1;
            for (int k = 0; k < 3; k++)
                if (g < 0 && h[(ptr + k) % 3] < rt[(ptr + k) % 3]) g = (ptr + k) % 3;
            done = 1'b0;
            while (!done) begin
                eg[n_exp] = 3'(g);
                ed[n_exp] = rb[g][h[g]].data;
                n_exp++;
                done = rb[g][h[g]].last;
                h[g]++;
                if (!done && h[g] >= rt[g]) begin
                    exp_ab++;
                    done = 1'b1;
                end
            end
            ptr = (g + 1) % 3;
        end
    endtask

    task automatic run_scenario(input string name);
        int ab0;
        run_model();
        sc_base = n_starts;
        ab0 = n_abort;
        drive_update();
        if (n_exp > 0) begin
            wait_starts(sc_base + n_exp, 4000);
            wait_idle(200);
        end
        check({name, "_byte_count"}, n_starts - sc_base, n_exp);
        check({name, "_abort_count"}, n_abort - ab0, exp_ab);
        for (int j = 0; j < n_exp && sc_base + j < n_starts; j++) begin
            check({name, "_grant"}, 32'(st_g[sc_base + j]), 32'(eg[j]));
            check({name, "_data"}, 32'(st_d[sc_base + j]), 32'(ed[j]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        int t0;
        int k;
        int ab0;
        int wd0;
        int nf;
        int len;
        bit trunc;

        // mask, d0, d1, d2, expected grant, expected data (rr pointer chains through)
        vt[0] = '{3'b010, 8'h00, 8'h4E, 8'h00, 3'd1, 8'h4E};
        vt[1] = '{3'b011, 8'h43, 8'h53, 8'h00, 3'd0, 8'h43};
        vt[2] = '{3'b101, 8'h45, 8'h00, 8'h57, 3'd2, 8'h57};
        vt[3] = '{3'b111, 8'h11, 8'h22, 8'h33, 3'd0, 8'h11};
        vt[4] = '{3'b100, 8'h00, 8'h00, 8'hA5, 3'd2, 8'hA5};
        vt[5] = '{3'b110, 8'h00, 8'h5A, 8'hC3, 3'd1, 8'h5A};
        vt[6] = '{3'b001, 8'hFF, 8'h00, 8'h00, 3'd0, 8'hFF};
        vt[7] = '{3'b111, 8'h01, 8'h02, 8'h03, 3'd1, 8'h02};

        rst_n    = 1'b0;
        busy_en  = 1'b1;
        busy_len = 6;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        do_reset();

        for (int v = 0; v < 8; v++) begin
            if (vt[v].mask[0]) push(0, vt[v].d0, 1'b1);
            if (vt[v].mask[1]) push(1, vt[v].d1, 1'b1);
            if (vt[v].mask[2]) push(2, vt[v].d2, 1'b1);
            drive_update();
            t0 = cyc;
            b = n_starts;
            k = 0;
            while (n_starts == b && k < 20) begin
                step();
                k++;
            end
            check("vec_start_seen", n_starts - b, 1);
            if (n_starts > b) begin
                check("vec_start_latency", st_c[b] - t0, 1);
                check("vec_grant", 32'(st_g[b]), 32'(vt[v].exp_g));
                check("vec_data", 32'(st_d[b]), 32'(vt[v].exp_d));
            end
            for (int i = 0; i < 3; i++) rh[i] = rt[i];
            drive_update();
            wait_idle(100);
        end

        // two-byte locked frame from 0 while 2 waits
        do_reset();
        push(0, 8'h43, 1'b0);
        push(0, 8'h39, 1'b1);
        push(2, 8'h46, 1'b1);
        run_scenario("frame2");
        if (n_starts >= sc_base + 3) begin
            check("frame2_g0", 32'(st_g[sc_base]), 0);
            check("frame2_g2_after_frame", 32'(st_g[sc_base + 2]), 2);
            check("frame2_locked_gap", st_gap[sc_base + 1], 1);
            check("frame2_between_frames_gap", st_gap[sc_base + 2], 2);
        end

        // all three held continuously: wraps 2 -> 0
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 3; i++) push(i, 8'(8'h30 + 8'(r * 3 + i)), 1'b1);
        run_scenario("rr6");
        if (n_starts >= sc_base + 6) begin
            check("rr6_wrap_to_0", 32'(st_g[sc_base + 3]), 0);
            check("rr6_last_is_2", 32'(st_g[sc_base + 5]), 2);
        end

        // requester 1 locks then drops req
        do_reset();
        push(1, 8'h57, 1'b0);
        push(2, 8'h45, 1'b1);
        ab0 = n_abort;
        run_scenario("abort");
        check("abort_pulse_once", n_abort - ab0, 1);
        if (n_starts >= sc_base + 2)
            check("abort_next_grant", 32'(st_g[sc_base + 1]), 2);

        // busy never rises: watchdog
        do_reset();
        busy_en = 1'b0;
        push(0, 8'h53, 1'b1);
        drive_update();
        b = n_starts;
        wd0 = n_wd;
        wait_starts(b + 1, 20);
        k = 0;
        while (n_wd == wd0 && k < 40) begin
            step();
            k++;
        end
        check("wd_pulse_count", n_wd - wd0, 1);
        if (n_starts > b) check("wd_delay_from_start", wd_cyc - st_c[b], 16);
        check("wd_frame_inactive", {31'd0, wd_fa}, 0);
        busy_en = 1'b1;
        push(1, 8'h45, 1'b1);
        drive_update();
        b = n_starts;
        wait_starts(b + 1, 20);
        if (n_starts > b) begin
            check("wd_relaunch_grant", 32'(st_g[b]), 1);
            check("wd_relaunch_data", 32'(st_d[b]), 32'h45);
        end
        wait_idle(100);

        // asynchronous reset in WAIT_DONE of a locked frame
        do_reset();
        push(0, 8'h43, 1'b0);
        push(0, 8'h39, 1'b1);
        push(1, 8'h4E, 1'b1);
        push(2, 8'h46, 1'b1);
        drive_update();
        b = n_starts;
        wait_starts(b + 1, 20);
        k = 0;
        while (!tx_busy && k < 10) begin
            step();
            k++;
        end
        step();
        check("pre_reset_frame_active", {31'd0, frame_active}, 1);
        ab0 = n_abort;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {tx_start, bus.ack, frame_active, frame_abort, wd_error, grant_id, tx_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_busy = 1'b0;
        b = n_starts;
        wait_starts(b + 3, 200);
        wait_idle(100);
        check("reset_no_abort", n_abort - ab0, 0);
        if (n_starts >= b + 3) begin
            check("post_reset_grant", 32'(st_g[b]), 0);
            check("post_reset_data", 32'(st_d[b]), 32'h39);
            check("post_reset_grant2", 32'(st_g[b + 1]), 1);
            check("post_reset_grant3", 32'(st_g[b + 2]), 2);
        end

        // randomized frame sets against the reference model
        for (int r = 0; r < 6; r++) begin
            do_reset();
            busy_len = $urandom_range(3, 8);
            for (int i = 0; i < 3; i++) begin
                nf = $urandom_range(0, 3);
                for (int f = 0; f < nf; f++) begin
                    len = $urandom_range(1, 3);
                    trunc = (f == nf - 1) && ($urandom_range(0, 3) == 0);
                    for (int bb = 0; bb < len; bb++)
                        push(i, 8'($urandom), (bb == len - 1) && !trunc);
                end
            end
            run_scenario("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
